// File: rtl/spc_stack_ctl.sv
// -----------------------------------------------------------------------------
// spc_stack_ctl
// Controller for the 32x19 synchronous SPC (subroutine return) stack RAM.
// Owns the stack pointer and a cached top-of-stack register. It sequences RAM
// writes for push and replace-top, and RAM reads for pop. After reset it
// clears the whole RAM. The RAM has a registered read, so every pop is
// followed by one REFILL cycle with READY low. During that cycle the RAM
// output is loaded into TOS.
//
// Ports
//   CLK        clock, all state changes on posedge
//   RESET_N    synchronous active-low reset
//   PUSH/POP   commands, sampled only while READY=1 (both = replace top)
//   DATA_IN    push / replace data
//   CLR_FLAGS  clears the sticky OVF/UNF flags (a same-cycle set wins)
//   READY      controller accepts a command this cycle
//   TOS        registered top of stack
//   PTR        stack pointer (address of the top entry)
//   COUNT      number of valid entries, 0..32
//   EMPTY/FULL COUNT==0 / COUNT==32
//   OVF/UNF    sticky overflow (push while FULL) / underflow (pop while EMPTY)
//   RAM_*      RAM address, write data, read data, active-low WE and CE
// -----------------------------------------------------------------------------
module spc_stack_ctl #(
  parameter int AW = 5,
  parameter int DW = 19
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          PUSH,
  input  logic          POP,
  input  logic [DW-1:0] DATA_IN,
  input  logic          CLR_FLAGS,
  output logic          READY,
  output logic [DW-1:0] TOS,
  output logic [AW-1:0] PTR,
  output logic [AW:0]   COUNT,
  output logic          EMPTY,
  output logic          FULL,
  output logic          OVF,
  output logic          UNF,
  output logic [AW-1:0] RAM_A,
  output logic [DW-1:0] RAM_DI,
  input  logic [DW-1:0] RAM_DO,
  output logic          RAM_WE_N,
  output logic          RAM_CE_N
);

  localparam int            DEPTH    = 2 ** AW;
  localparam logic [AW-1:0] ADDR_ONE = AW'(1);
  localparam logic [AW-1:0] ADDR_MAX = AW'(DEPTH - 1);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_REFILL = 2'd2
  } state_t;

  state_t        r_state;
  logic [AW-1:0] r_init_cnt;
  logic [AW-1:0] r_ptr;
  logic [AW:0]   r_count;
  logic [DW-1:0] r_tos;
  logic          r_ovf;
  logic          r_unf;

  logic          w_ready;
  logic          w_push_only;
  logic          w_pop_only;
  logic          w_replace;
  logic          w_full;
  logic          w_empty;
  logic          w_set_ovf;
  logic          w_set_unf;

  // Commands are only decoded while IDLE; anything else is ignored.
  assign w_ready     = (r_state == ST_IDLE);
  assign w_push_only = w_ready & PUSH & ~POP;
  assign w_pop_only  = w_ready & POP & ~PUSH;
  assign w_replace   = w_ready & PUSH & POP;
  assign w_full      = (r_count == CNT_FULL);
  assign w_empty     = (r_count == '0);
  assign w_set_ovf   = w_push_only & w_full;
  assign w_set_unf   = w_pop_only & w_empty;

  assign READY = w_ready;
  assign TOS   = r_tos;
  assign PTR   = r_ptr;
  assign COUNT = r_count;
  assign EMPTY = w_empty;
  assign FULL  = w_full;
  assign OVF   = r_ovf;
  assign UNF   = r_unf;

  // RAM strobes: the write or read happens on the same edge that accepts the command.
  always_comb begin
    RAM_CE_N = 1'b1;
    RAM_WE_N = 1'b1;
    RAM_A    = r_ptr;
    RAM_DI   = '0;
    if (!RESET_N) begin
      // Keep the RAM deselected while reset is applied.
      RAM_CE_N = 1'b1;
    end else begin
      case (r_state)
        ST_INIT: begin
          RAM_CE_N = 1'b0;
          RAM_WE_N = 1'b0;
          RAM_A    = r_init_cnt;
        end
        ST_IDLE: begin
          if (w_replace) begin
            RAM_CE_N = 1'b0;
            RAM_WE_N = 1'b0;
            RAM_A    = r_ptr;
            RAM_DI   = DATA_IN;
          end else if (w_push_only) begin
            RAM_CE_N = 1'b0;
            RAM_WE_N = 1'b0;
            RAM_A    = r_ptr + ADDR_ONE;
            RAM_DI   = DATA_IN;
          end else if (w_pop_only) begin
            // Read the entry below the one being popped so that it can become the new TOS.
            RAM_CE_N = 1'b0;
            RAM_A    = r_ptr - ADDR_ONE;
          end else begin
            RAM_CE_N = 1'b1;
          end
        end
        ST_REFILL: begin
          RAM_CE_N = 1'b1;
        end
        default: begin
          RAM_CE_N = 1'b1;
        end
      endcase
    end
  end

  // Controller state: RAM clear sweep, command execution, TOS refill, sticky flags.
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      r_state    <= ST_INIT;
      r_init_cnt <= '0;
      r_ptr      <= '0;
      r_count    <= '0;
      r_tos      <= '0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
          r_init_cnt <= r_init_cnt + ADDR_ONE;
          if (r_init_cnt == ADDR_MAX) begin
            r_state <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (w_replace) begin
            r_tos <= DATA_IN;
            if (w_empty) begin
              r_count <= CNT_ONE;
            end
          end else if (w_push_only) begin
            r_ptr <= r_ptr + ADDR_ONE;
            r_tos <= DATA_IN;
            // A push onto a full stack wraps and overwrites the oldest entry.
            if (!w_full) begin
              r_count <= r_count + CNT_ONE;
            end
          end else if (w_pop_only) begin
            // TOS keeps the popped value this cycle; the refill loads the new top.
            r_ptr   <= r_ptr - ADDR_ONE;
            r_state <= ST_REFILL;
            if (!w_empty) begin
              r_count <= r_count - CNT_ONE;
            end
          end
        end
        ST_REFILL: begin
          r_tos   <= RAM_DO;
          r_state <= ST_IDLE;
        end
        default: begin
          r_state    <= ST_INIT;
          r_init_cnt <= '0;
        end
      endcase
      // A set event in the same cycle takes priority over CLR_FLAGS.
      r_ovf <= w_set_ovf | (r_ovf & ~CLR_FLAGS);
      r_unf <= w_set_unf | (r_unf & ~CLR_FLAGS);
    end
  end

endmodule

// File: tb/tb_spc_stack_ctl.sv
module tb_spc_stack_ctl;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        PUSH = 1'b0;
  logic        POP = 1'b0;
  logic [18:0] DATA_IN = 19'd0;
  logic        CLR_FLAGS = 1'b0;
  logic        READY;
  logic [18:0] TOS;
  logic [4:0]  PTR;
  logic [5:0]  COUNT;
  logic        EMPTY, FULL, OVF, UNF;
  logic [4:0]  RAM_A;
  logic [18:0] RAM_DI;
  logic [18:0] RAM_DO;
  logic        RAM_WE_N, RAM_CE_N;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural RAM: 32x19, synchronous write, registered read. It is preloaded with junk so that the clear sweep is observable.
  logic [18:0] ram [0:31] = '{default: 19'h5A5A5};
  logic [18:0] ram_do = 19'd0;
  assign RAM_DO = ram_do;
  always @(posedge CLK) begin
    if (!RAM_CE_N) begin
      if (!RAM_WE_N) ram[RAM_A] <= RAM_DI;
      else ram_do <= ram[RAM_A];
    end
  end

  spc_stack_ctl dut (
    .CLK(CLK), .RESET_N(RESET_N), .PUSH(PUSH), .POP(POP), .DATA_IN(DATA_IN),
    .CLR_FLAGS(CLR_FLAGS), .READY(READY), .TOS(TOS), .PTR(PTR), .COUNT(COUNT),
    .EMPTY(EMPTY), .FULL(FULL), .OVF(OVF), .UNF(UNF), .RAM_A(RAM_A),
    .RAM_DI(RAM_DI), .RAM_DO(RAM_DO), .RAM_WE_N(RAM_WE_N), .RAM_CE_N(RAM_CE_N)
  );

  always #5 CLK = ~CLK;

  // Reference model: the stack is an array plus a pointer and an entry count.
  logic [18:0] m_mem [0:31];
  int          m_ptr = 0, m_cnt = 0, m_init = 0;
  logic [18:0] m_tos = 19'd0;
  bit          m_ovf = 0, m_unf = 0, m_refill = 0;

  function automatic bit m_ready();
    return (m_init == 32) && !m_refill;
  endfunction

  task automatic drive(input bit p, input bit q, input logic [18:0] d, input bit c);
    PUSH = p; POP = q; DATA_IN = d; CLR_FLAGS = c;
    #1;
  endtask

  // Applies one clock edge to the model using the currently driven inputs, then steps the DUT.
  task automatic edge_step();
    bit so = 0, su = 0;
    if (!RESET_N) begin
      m_init = 0; m_ptr = 0; m_cnt = 0; m_tos = 19'd0;
      m_ovf = 0; m_unf = 0; m_refill = 0;
    end else begin
      if (m_init < 32) begin
        m_mem[m_init] = 19'd0; m_init++;
      end else if (m_refill) begin
        m_tos = m_mem[m_ptr]; m_refill = 0;
      end else if (PUSH && POP) begin
        m_mem[m_ptr] = DATA_IN; m_tos = DATA_IN;
        if (m_cnt == 0) m_cnt = 1;
      end else if (PUSH) begin
        m_ptr = (m_ptr + 1) % 32; m_mem[m_ptr] = DATA_IN; m_tos = DATA_IN;
        if (m_cnt < 32) m_cnt++; else so = 1;
      end else if (POP) begin
        m_ptr = (m_ptr + 31) % 32; m_refill = 1;
        if (m_cnt > 0) m_cnt--; else su = 1;
      end
      m_ovf = so | (m_ovf & !CLR_FLAGS);
      m_unf = su | (m_unf & !CLR_FLAGS);
    end
    @(posedge CLK); #1;
  endtask

  task automatic tick(input bit p, input bit q, input logic [18:0] d, input bit c);
    drive(p, q, d, c);
    edge_step();
  endtask

  task automatic reset_init();
    RESET_N = 1'b0; drive(0, 0, 19'd0, 0); edge_step();
    RESET_N = 1'b1;
    for (int i = 0; i < 32; i++) edge_step();
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; drive(0, 0, 19'd0, 0);
    vectors++; if ({RAM_CE_N, RAM_WE_N} !== 2'b11) begin miscompares++; $display("FAIL rst_ram_idle got ce_n=%b we_n=%b want 1 1", RAM_CE_N, RAM_WE_N); end
    edge_step(); edge_step();
    vectors++; if ({READY, EMPTY, FULL, OVF, UNF} !== 5'b01000) begin miscompares++; $display("FAIL rst_flags got rdy=%b empty=%b full=%b ovf=%b unf=%b want 0 1 0 0 0", READY, EMPTY, FULL, OVF, UNF); end
    vectors++; if (PTR !== 5'd0 || COUNT !== 6'd0 || TOS !== 19'd0) begin miscompares++; $display("FAIL rst_regs got ptr=%0d cnt=%0d tos=%0o want 0 0 0", PTR, COUNT, TOS); end
    RESET_N = 1'b1; #1;
    for (int i = 0; i < 32; i++) begin
      vectors++;
      if (READY !== 1'b0 || RAM_CE_N !== 1'b0 || RAM_WE_N !== 1'b0 || RAM_A !== 5'(i) || RAM_DI !== 19'd0) begin
        miscompares++; $display("FAIL init_cycle%0d got rdy=%b ce_n=%b we_n=%b a=%0d di=%0o want 0 0 0 %0d 0", i, READY, RAM_CE_N, RAM_WE_N, RAM_A, RAM_DI, i);
      end
      edge_step();
    end
    vectors++; if (READY !== 1'b1 || PTR !== 5'd0 || COUNT !== 6'd0 || EMPTY !== 1'b1 || TOS !== 19'd0) begin miscompares++; $display("FAIL init_done got rdy=%b ptr=%0d cnt=%0d empty=%b tos=%0o want 1 0 0 1 0", READY, PTR, COUNT, EMPTY, TOS); end
    for (int k = 0; k < 32; k++) begin
      vectors++; if (ram[k] !== 19'd0) begin miscompares++; $display("FAIL init_clear addr %0d got %0o want 0", k, ram[k]); end
    end
  endtask

  task automatic test_push_pop();
    logic [18:0] vals [3];
    vals[0] = 19'o1234567; vals[1] = 19'o0000001; vals[2] = 19'o7654321;
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, vals[i], 0);
      vectors++; if (RAM_A !== 5'(i + 1) || RAM_CE_N !== 1'b0 || RAM_WE_N !== 1'b0 || RAM_DI !== vals[i]) begin miscompares++; $display("FAIL push_ram%0d got a=%0d ce_n=%b we_n=%b di=%0o want %0d 0 0 %0o", i, RAM_A, RAM_CE_N, RAM_WE_N, RAM_DI, i + 1, vals[i]); end
      edge_step();
    end
    drive(0, 0, 19'd0, 0);
    vectors++; if (PTR !== 5'd3 || COUNT !== 6'd3 || TOS !== 19'o7654321) begin miscompares++; $display("FAIL push3 got ptr=%0d cnt=%0d tos=%0o want 3 3 7654321", PTR, COUNT, TOS); end
    vectors++; if (ram[1] !== vals[0] || ram[2] !== vals[1] || ram[3] !== vals[2]) begin miscompares++; $display("FAIL push3_mem got %0o %0o %0o", ram[1], ram[2], ram[3]); end
    drive(0, 1, 19'd0, 0);
    vectors++; if (RAM_A !== 5'd2 || RAM_CE_N !== 1'b0 || RAM_WE_N !== 1'b1 || TOS !== 19'o7654321) begin miscompares++; $display("FAIL pop_read got a=%0d ce_n=%b we_n=%b tos=%0o want 2 0 1 7654321", RAM_A, RAM_CE_N, RAM_WE_N, TOS); end
    edge_step(); drive(0, 0, 19'd0, 0);
    vectors++; if (READY !== 1'b0 || PTR !== 5'd2 || COUNT !== 6'd2) begin miscompares++; $display("FAIL pop_refill got rdy=%b ptr=%0d cnt=%0d want 0 2 2", READY, PTR, COUNT); end
    edge_step();
    vectors++; if (READY !== 1'b1 || TOS !== 19'o0000001) begin miscompares++; $display("FAIL pop_tos got rdy=%b tos=%0o want 1 1", READY, TOS); end
    tick(0, 1, 19'd0, 0); tick(0, 0, 19'd0, 0);
    tick(0, 1, 19'd0, 0); tick(0, 0, 19'd0, 0);
    vectors++; if (TOS !== 19'd0 || EMPTY !== 1'b1 || PTR !== 5'd0 || UNF !== 1'b0) begin miscompares++; $display("FAIL pop_to_empty got tos=%0o empty=%b ptr=%0d unf=%b want 0 1 0 0", TOS, EMPTY, PTR, UNF); end
  endtask

  task automatic test_overflow();
    reset_init();
    for (int v = 1; v <= 32; v++) tick(1, 0, 19'(v), 0);
    vectors++; if (FULL !== 1'b1 || OVF !== 1'b0 || PTR !== 5'd0 || COUNT !== 6'd32) begin miscompares++; $display("FAIL full32 got full=%b ovf=%b ptr=%0d cnt=%0d want 1 0 0 32", FULL, OVF, PTR, COUNT); end
    tick(1, 0, 19'd33, 0);
    vectors++; if (OVF !== 1'b1 || PTR !== 5'd1 || COUNT !== 6'd32 || ram[1] !== 19'd33 || TOS !== 19'd33) begin miscompares++; $display("FAIL ovf_wrap got ovf=%b ptr=%0d cnt=%0d mem1=%0d tos=%0d want 1 1 32 33 33", OVF, PTR, COUNT, ram[1], TOS); end
    tick(0, 0, 19'd0, 1);
    vectors++; if (OVF !== 1'b0) begin miscompares++; $display("FAIL ovf_clear got %b want 0", OVF); end
    tick(1, 0, 19'd34, 1);
    vectors++; if (OVF !== 1'b1 || PTR !== 5'd2) begin miscompares++; $display("FAIL ovf_set_wins got ovf=%b ptr=%0d want 1 2", OVF, PTR); end
  endtask

  task automatic test_underflow();
    reset_init();
    drive(0, 1, 19'd0, 0);
    vectors++; if (RAM_A !== 5'd31 || RAM_CE_N !== 1'b0 || RAM_WE_N !== 1'b1) begin miscompares++; $display("FAIL unf_read got a=%0d ce_n=%b we_n=%b want 31 0 1", RAM_A, RAM_CE_N, RAM_WE_N); end
    edge_step();
    vectors++; if (UNF !== 1'b1 || PTR !== 5'd31 || COUNT !== 6'd0 || READY !== 1'b0 || EMPTY !== 1'b1) begin miscompares++; $display("FAIL unf_set got unf=%b ptr=%0d cnt=%0d rdy=%b empty=%b want 1 31 0 0 1", UNF, PTR, COUNT, READY, EMPTY); end
    edge_step(); drive(0, 0, 19'd0, 0);
    vectors++; if (READY !== 1'b1 || TOS !== 19'd0 || PTR !== 5'd31 || COUNT !== 6'd0) begin miscompares++; $display("FAIL unf_refill got rdy=%b tos=%0o ptr=%0d cnt=%0d want 1 0 31 0", READY, TOS, PTR, COUNT); end
  endtask

  task automatic test_replace();
    reset_init();
    tick(1, 0, 19'd5, 0);
    drive(1, 1, 19'd9, 0);
    vectors++; if (RAM_A !== 5'd1 || RAM_WE_N !== 1'b0 || RAM_CE_N !== 1'b0 || RAM_DI !== 19'd9) begin miscompares++; $display("FAIL repl_ram got a=%0d we_n=%b ce_n=%b di=%0d want 1 0 0 9", RAM_A, RAM_WE_N, RAM_CE_N, RAM_DI); end
    edge_step(); drive(0, 0, 19'd0, 0);
    vectors++; if (ram[1] !== 19'd9 || PTR !== 5'd1 || COUNT !== 6'd1 || TOS !== 19'd9) begin miscompares++; $display("FAIL repl got mem1=%0d ptr=%0d cnt=%0d tos=%0d want 9 1 1 9", ram[1], PTR, COUNT, TOS); end
    tick(0, 1, 19'd0, 0);
    tick(0, 1, 19'd0, 0);
    drive(0, 0, 19'd0, 0);
    vectors++; if (PTR !== 5'd0 || COUNT !== 6'd0 || READY !== 1'b1 || TOS !== 19'd0) begin miscompares++; $display("FAIL pop_in_refill got ptr=%0d cnt=%0d rdy=%b tos=%0o want 0 0 1 0", PTR, COUNT, READY, TOS); end
    tick(1, 1, 19'd7, 0);
    vectors++; if (COUNT !== 6'd1 || PTR !== 5'd0 || TOS !== 19'd7 || ram[0] !== 19'd7 || OVF !== 1'b0 || UNF !== 1'b0) begin miscompares++; $display("FAIL repl_empty got cnt=%0d ptr=%0d tos=%0d mem0=%0d ovf=%b unf=%b want 1 0 7 7 0 0", COUNT, PTR, TOS, ram[0], OVF, UNF); end
  endtask

  task automatic test_reset_mid();
    RESET_N = 1'b0; drive(0, 0, 19'd0, 0); edge_step();
    RESET_N = 1'b1;
    for (int i = 0; i < 10; i++) edge_step();
    vectors++; if (RAM_A !== 5'd10 || READY !== 1'b0) begin miscompares++; $display("FAIL mid_init_addr got a=%0d rdy=%b want 10 0", RAM_A, READY); end
    RESET_N = 1'b0; #1;
    vectors++; if ({RAM_CE_N, RAM_WE_N} !== 2'b11) begin miscompares++; $display("FAIL mid_init_rst_idle got ce_n=%b we_n=%b want 1 1", RAM_CE_N, RAM_WE_N); end
    edge_step();
    RESET_N = 1'b1; #1;
    for (int i = 0; i < 32; i++) begin
      vectors++; if (READY !== 1'b0 || RAM_A !== 5'(i) || RAM_WE_N !== 1'b0) begin miscompares++; $display("FAIL resweep%0d got rdy=%b a=%0d we_n=%b want 0 %0d 0", i, READY, RAM_A, RAM_WE_N, i); end
      edge_step();
    end
    vectors++; if (READY !== 1'b1) begin miscompares++; $display("FAIL resweep_done got rdy=%b want 1", READY); end
    tick(1, 0, 19'd77, 0);
    tick(0, 1, 19'd0, 0);
    tick(0, 1, 19'd0, 0);
    tick(0, 1, 19'd0, 0);
    vectors++; if (READY !== 1'b0 || UNF !== 1'b1) begin miscompares++; $display("FAIL pre_refill_rst got rdy=%b unf=%b want 0 1", READY, UNF); end
    RESET_N = 1'b0; drive(0, 0, 19'd0, 0); edge_step();
    RESET_N = 1'b1; #1;
    vectors++; if (UNF !== 1'b0 || PTR !== 5'd0 || COUNT !== 6'd0 || TOS !== 19'd0 || READY !== 1'b0 || RAM_A !== 5'd0 || RAM_WE_N !== 1'b0) begin miscompares++; $display("FAIL refill_rst got unf=%b ptr=%0d cnt=%0d tos=%0o rdy=%b a=%0d we_n=%b", UNF, PTR, COUNT, TOS, READY, RAM_A, RAM_WE_N); end
    for (int i = 0; i < 32; i++) edge_step();
    vectors++; if (READY !== 1'b1 || EMPTY !== 1'b1) begin miscompares++; $display("FAIL refill_rst_done got rdy=%b empty=%b want 1 1", READY, EMPTY); end
  endtask

  task automatic test_random();
    logic [6:0] exp_st, got_st;
    reset_init();
    for (int n = 0; n < 1200; n++) begin
      int bias;
      bias = ((n / 150) % 2 == 0) ? 70 : 25;
      RESET_N = ($urandom_range(0, 399) != 0);
      drive($urandom_range(0, 99) < bias, $urandom_range(0, 99) < (95 - bias),
            19'($urandom), $urandom_range(0, 9) == 0);
      edge_step();
      RESET_N = 1'b1;
      exp_st = {m_ready(), 5'(m_ptr), 1'(m_cnt == 0)};
      got_st = {READY, PTR, EMPTY};
      vectors++; if (got_st !== exp_st || COUNT !== 6'(m_cnt) || FULL !== (m_cnt == 32) || OVF !== m_ovf || UNF !== m_unf) begin
        miscompares++; $display("FAIL rand_status step %0d got rdy/ptr/empty=%b cnt=%0d full=%b ovf=%b unf=%b want %b %0d %b %b %b", n, got_st, COUNT, FULL, OVF, UNF, exp_st, m_cnt, m_cnt == 32, m_ovf, m_unf);
      end
      vectors++; if (TOS !== m_tos) begin miscompares++; $display("FAIL rand_tos step %0d got %0o want %0o", n, TOS, m_tos); end
    end
    for (int i = 0; i < 40; i++) tick(0, 0, 19'd0, 0);
    for (int k = 0; k < 32; k++) begin
      vectors++; if (ram[k] !== m_mem[k]) begin miscompares++; $display("FAIL rand_mem addr %0d got %0o want %0o", k, ram[k], m_mem[k]); end
    end
  endtask

  initial begin
    test_reset();
    test_push_pop();
    test_overflow();
    test_underflow();
    test_replace();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spc_stack_ctl.md
Name: spc_stack_ctl

Overview:
- Controller for the 32x19 synchronous SPC (subroutine return) stack RAM.
- Owns the stack pointer and a cached top-of-stack (TOS) register, and sequences RAM writes and reads for push, pop and replace-top.
- Clears the RAM after reset.
- The RAM has 1-cycle registered read latency, so a pop needs a refill cycle, during which READY is low.

Parameters:
AW, 5, RAM address width; depth = 2**AW = 32
DW, 19, data width

Ports:
CLK  input  1  clock; all state changes on posedge
RESET_N  input  1  synchronous, active-low reset
PUSH  input  1  push DATA_IN; sampled only when READY=1
POP  input  1  pop TOS; sampled only when READY=1
DATA_IN  input  DW  push / replace data
CLR_FLAGS  input  1  clears OVF and UNF
READY  output  1  controller accepts a command this cycle
TOS  output  DW  current top of stack (registered)
PTR  output  AW  stack pointer, address of the top entry
COUNT  output  AW+1  valid entries, 0..32
EMPTY  output  1  COUNT==0
FULL  output  1  COUNT==32
OVF  output  1  sticky: push while FULL
UNF  output  1  sticky: pop while EMPTY
RAM_A  output  AW  RAM address
RAM_DI  output  DW  RAM write data
RAM_DO  input  DW  RAM registered read data
RAM_WE_N  output  1  RAM write enable, active low
RAM_CE_N  output  1  RAM chip enable, active low

Behaviour:
- RAM_* outputs: combinational from state and inputs; write and read occur on the same CLK edge as the command. RAM_WE_N=RAM_CE_N=1 whenever RESET_N=0 and in any idle cycle.
- Reset (RESET_N=0 at posedge): state=INIT, init_cnt=0, PTR=0, COUNT=0, TOS=0, OVF=UNF=0. READY=0; EMPTY=1; FULL=0. Reset asserted in any state, including mid-INIT or in REFILL, restarts INIT from address 0.
- INIT: each cycle RAM_CE_N=0, RAM_WE_N=0, RAM_A=init_cnt, RAM_DI=0, then init_cnt++. After writing address 31, go to IDLE. READY first goes high in the 33rd cycle after RESET_N rises.
- IDLE, READY=1:
  - PUSH only:
    - RAM_A=PTR+1 (mod 32), RAM_DI=DATA_IN, write.
    - PTR<=PTR+1, TOS<=DATA_IN.
    - If COUNT<32, COUNT++; else OVF<=1, COUNT stays 32 and the oldest entry is overwritten (wrap).
  - POP only:
    - RAM_A=PTR-1 (mod 32), RAM_CE_N=0, RAM_WE_N=1.
    - PTR<=PTR-1; state<=REFILL.
    - If COUNT>0, COUNT--; else UNF<=1, COUNT stays 0 and PTR still wraps.
    - TOS holds its old value during this cycle: the requester reads the popped value off TOS in the same cycle it asserts POP.
  - PUSH and POP together (replace top):
    - RAM_A=PTR, write DATA_IN; TOS<=DATA_IN; PTR unchanged.
    - COUNT unchanged, except 0 becomes 1. No flag change.
  - Neither: no RAM access.
- REFILL: READY=0, no RAM access. TOS<=RAM_DO, holding the data for address PTR. Return to IDLE; the next command is accepted the cycle after.
- PUSH/POP while READY=0 are ignored, with no side effects. The requester holds its command until READY=1.
- CLR_FLAGS clears OVF/UNF. If it coincides with a setting event, the set wins.
- Pop latency: TOS is valid for the new top 2 cycles after the POP edge. Push/replace TOS is updated at the next edge.

Test Plan:
- Reset, then wait: READY=0 for 32 cycles with writes to addresses 0..31 of value 0; READY=1 at cycle 33; PTR=0, COUNT=0, EMPTY=1, TOS=0.
- Push 19'o1234567, 19'o0000001, 19'o7654321 -> RAM addresses 1,2,3 written; PTR=3, COUNT=3, TOS=19'o7654321. Pop -> READY low 1 cycle, then TOS=19'o0000001, PTR=2, COUNT=2. Pop twice more -> TOS=0, EMPTY=1.
- 33 consecutive pushes of values 1..33 -> after the 32nd, FULL=1, OVF=0, PTR=0; the 33rd sets OVF=1, PTR=1, address 1 = 33, COUNT=32. CLR_FLAGS -> OVF=0.
- Pop while EMPTY from reset -> UNF=1, PTR=31, COUNT=0, and after REFILL TOS=0.
- Push 5, then PUSH+POP with DATA_IN=9 -> address 1 = 9, PTR=1, COUNT=1, TOS=9. POP asserted during REFILL -> ignored, PTR unchanged.
- Assert RESET_N=0 during INIT at init_cnt=10, and again during a REFILL cycle -> INIT restarts at address 0, full 32-cycle sweep, all state at reset values.
